// File: rtl/ps2_pkg.sv
// Shared constants and prefix-state encoding for the PS/2 receive path.
package ps2_pkg;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } prefix_state_t;
endpackage

// File: rtl/ps2_clk_filter.sv
// PS2_CLK synchroniser + FILTER_LEN-sample debounce; fe is a 1-cycle falling-edge strobe.
// Latency raw edge -> fe is 2 sync + FILTER_LEN cycles; no backpressure.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  output logic o_fe
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt;
  logic          r_filt_q;

  // Bus idles high, so the synchroniser and filter come out of reset at 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync   <= 2'b11;
      r_cnt    <= '0;
      r_filt   <= 1'b1;
      r_filt_q <= 1'b1;
    end else begin
      r_sync   <= {r_sync[0], i_ps2_clk};
      r_filt_q <= r_filt;
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fe = r_filt_q & ~r_filt;
endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: checks start/parity/stop, folds E0/F0 prefixes into flags.
// CODE_VALID/FRAME_ERR strobe 1 cycle after the 11th falling edge; no backpressure. Option: PS2_ERR_COUNT_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] SCAN_CODE,
  output logic       EXTENDED,
  output logic       BREAK,
  output logic       CODE_VALID,
  output logic       FRAME_ERR
`ifdef PS2_ERR_COUNT_EN
  ,
  output logic [7:0] ERR_COUNT
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC);
  localparam logic [3:0]    BIT_LAST = 4'(PS2_FRAME_BITS - 1);

  logic [1:0]                r_rst_sync;
  logic                      w_rst;
  logic                      w_fe;
  logic [1:0]                r_dat_sync;
  logic [PS2_FRAME_BITS-1:0] r_shift;
  logic [PS2_FRAME_BITS-1:0] w_frame;
  logic [3:0]                r_bit_cnt;
  logic [TW-1:0]             r_to_cnt;
  logic                      w_to_hit;
  logic                      w_frame_last;
  logic                      w_frame_ok;
  logic [7:0]                w_byte;
  prefix_state_t             r_state, w_state_nxt;
  logic                      w_emit, w_emit_ext, w_emit_brk, w_err;
  logic [7:0]                r_scan;
  logic                      r_ext, r_brk, r_code_valid, r_frame_err;

  // Async assert, synchronous release of the internal reset.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) r_rst_sync <= 2'b11;
    else       r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .i_clk     (CLOCK_50),
    .i_rst     (w_rst),
    .i_ps2_clk (PS2_CLK),
    .o_fe      (w_fe)
  );

  // Checks look at the frame including the bit arriving this cycle, so results register on the 11th edge.
  assign w_frame      = {r_dat_sync[1], r_shift[PS2_FRAME_BITS-1:1]};
  assign w_byte       = w_frame[8:1];
  assign w_frame_last = w_fe && (r_bit_cnt == BIT_LAST);
  assign w_frame_ok   = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
  assign w_to_hit     = !w_fe && (r_bit_cnt != 4'd0) && (r_to_cnt == TO_LAST);

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_dat_sync <= 2'b11;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_dat_sync <= {r_dat_sync[0], PS2_DAT};
      if (w_fe) begin
        r_shift   <= w_frame;
        r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? 4'd0 : r_bit_cnt + 4'd1;
      end else if (w_to_hit) begin
        r_bit_cnt <= '0;
      end
      if (w_fe || w_to_hit || (r_bit_cnt == 4'd0)) r_to_cnt <= '0;
      else                                         r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_emit_ext  = 1'b0;
    w_emit_brk  = 1'b0;
    w_err       = 1'b0;
    if (w_to_hit || (w_frame_last && !w_frame_ok)) begin
      w_err       = 1'b1;
      w_state_nxt = IDLE;
    end else if (w_frame_last) begin
      case (r_state)
        IDLE: begin
          if (w_byte == PS2_PREFIX_EXT)      w_state_nxt = EXT;
          else if (w_byte == PS2_PREFIX_BRK) w_state_nxt = BRK;
          else                               w_emit = 1'b1;
        end
        EXT: begin
          if (w_byte == PS2_PREFIX_BRK) begin
            w_state_nxt = EXT_BRK;
          end else if (w_byte != PS2_PREFIX_EXT) begin
            w_emit      = 1'b1;
            w_emit_ext  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          w_state_nxt = IDLE;
          if (w_byte == PS2_PREFIX_EXT || w_byte == PS2_PREFIX_BRK) begin
            w_err = 1'b1;
          end else begin
            w_emit     = 1'b1;
            w_emit_ext = (r_state == EXT_BRK);
            w_emit_brk = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_scan       <= '0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= w_emit;
      r_frame_err  <= w_err;
      if (w_emit) begin
        r_scan <= w_byte;
        r_ext  <= w_emit_ext;
        r_brk  <= w_emit_brk;
      end
    end
  end

  assign SCAN_CODE  = r_scan;
  assign EXTENDED   = r_ext;
  assign BREAK      = r_brk;
  assign CODE_VALID = r_code_valid;
  assign FRAME_ERR  = r_frame_err;

`ifdef PS2_ERR_COUNT_EN
  logic [7:0] r_err_count;
  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst)                             r_err_count <= '0;
    else if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end
  assign ERR_COUNT = r_err_count;
`endif
endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: hand-computed frames, error cases, timeout, glitch and mid-frame reset.
module tb_ps2_frame_rx;
  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] SCAN_CODE;
  logic       EXTENDED, BREAK, CODE_VALID, FRAME_ERR;
`ifdef PS2_ERR_COUNT_EN
  logic [7:0] ERR_COUNT;
`endif

  ps2_frame_rx dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .SCAN_CODE  (SCAN_CODE),
    .EXTENDED   (EXTENDED),
    .BREAK      (BREAK),
    .CODE_VALID (CODE_VALID),
    .FRAME_ERR  (FRAME_ERR)
`ifdef PS2_ERR_COUNT_EN
    ,
    .ERR_COUNT  (ERR_COUNT)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Event monitor: counts strobes and latches what came with them.
  int         cv_cnt = 0, cv_cyc = 0, fe_cnt = 0, fe_cyc = 0;
  logic [7:0] cv_code = '0;
  logic       cv_ext = 1'b0, cv_brk = 1'b0;
  always @(negedge CLOCK_50) begin
    if (CODE_VALID) begin
      cv_cnt  <= cv_cnt + 1;
      cv_cyc  <= cyc;
      cv_code <= SCAN_CODE;
      cv_ext  <= EXTENDED;
      cv_brk  <= BREAK;
    end
    if (FRAME_ERR) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
  end

  int n_vec = 0, n_err = 0;
  int last_fall = 0;
  int cv0, fe0, k5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge CLOCK_50);
    PS2_DAT = v;
    repeat (4) @(negedge CLOCK_50);
    PS2_CLK   = 1'b0;
    last_fall = cyc;
    repeat (8) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (3) @(negedge CLOCK_50);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_flip);
    return {1'b1, (~^b) ^ par_flip, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic par_flip);
    logic [10:0] f;
    f = mk_frame(b, par_flip);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
  endtask

  initial begin
    repeat (5) @(negedge CLOCK_50);
    RESET = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("rst_scan", {24'd0, SCAN_CODE}, 32'h0);
    check("rst_ext",  {31'd0, EXTENDED},  32'h0);
    check("rst_brk",  {31'd0, BREAK},     32'h0);
    check("rst_cv",   {31'd0, CODE_VALID}, 32'h0);
    check("rst_ferr", {31'd0, FRAME_ERR}, 32'h0);

    // Plain make code 1C
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0);
    check("1c_cnt",  cv_cnt - cv0, 1);
    check("1c_lat",  cv_cyc - last_fall, 7);
    check("1c_code", {24'd0, cv_code}, 32'h1C);
    check("1c_ext",  {31'd0, cv_ext}, 32'h0);
    check("1c_brk",  {31'd0, cv_brk}, 32'h0);
    check("1c_nerr", fe_cnt - fe0, 0);

    // Break: F0 1C
    cv0 = cv_cnt;
    send_frame(8'hF0, 1'b0);
    check("f0_nocv", cv_cnt - cv0, 0);
    send_frame(8'h1C, 1'b0);
    check("brk_cnt",  cv_cnt - cv0, 1);
    check("brk_code", {24'd0, cv_code}, 32'h1C);
    check("brk_ext",  {31'd0, cv_ext}, 32'h0);
    check("brk_brk",  {31'd0, cv_brk}, 32'h1);

    // Extended break: E0 F0 75, then plain 1C
    cv0 = cv_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("xb_cnt",  cv_cnt - cv0, 1);
    check("xb_code", {24'd0, cv_code}, 32'h75);
    check("xb_ext",  {31'd0, cv_ext}, 32'h1);
    check("xb_brk",  {31'd0, cv_brk}, 32'h1);
    send_frame(8'h1C, 1'b0);
    check("post_code", {24'd0, cv_code}, 32'h1C);
    check("post_ext",  {31'd0, cv_ext}, 32'h0);
    check("post_brk",  {31'd0, cv_brk}, 32'h0);
    check("post_nerr", fe_cnt - fe0, 0);

    // Parity error
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1);
    check("par_err",  fe_cnt - fe0, 1);
    check("par_lat",  fe_cyc - last_fall, 7);
    check("par_nocv", cv_cnt - cv0, 0);
`ifdef PS2_ERR_COUNT_EN
    check("par_errcnt", {24'd0, ERR_COUNT}, 32'h1);
`endif

    // Prefix after break is an error
    send_frame(8'hF0, 1'b0);
    send_frame(8'hE0, 1'b0);
    check("bp_err",  fe_cnt - fe0, 2);
    check("bp_nocv", cv_cnt - cv0, 0);

    // Timeout after five bits
    begin
      logic [10:0] f;
      f = mk_frame(8'h1C, 1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    end
    k5 = last_fall;
    fe0 = fe_cnt;
    for (int i = 0; i < 50100 && fe_cnt == fe0; i++) begin
      @(negedge CLOCK_50);
      #1;
    end
    check("to_err", fe_cnt - fe0, 1);
    check("to_cyc", fe_cyc - k5, 50008);
    cv0 = cv_cnt;
    send_frame(8'h32, 1'b0);
    check("to_next_cnt",  cv_cnt - cv0, 1);
    check("to_next_code", {24'd0, cv_code}, 32'h32);
    check("to_next_flags", {30'd0, cv_ext, cv_brk}, 32'h0);

    // Two-cycle low glitch on an idle bus must be invisible
    cv0 = cv_cnt; fe0 = fe_cnt;
    @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    check("gl_nocv",  cv_cnt - cv0, 0);
    check("gl_noerr", fe_cnt - fe0, 0);
    send_frame(8'h1C, 1'b0);
    check("gl_cnt",  cv_cnt - cv0, 1);
    check("gl_code", {24'd0, cv_code}, 32'h1C);
    check("gl_noerr2", fe_cnt - fe0, 0);

    // Reset after six bits of 24
    begin
      logic [10:0] f;
      f = mk_frame(8'h24, 1'b0);
      for (int i = 0; i < 6; i++) ps2_bit(f[i]);
    end
    @(negedge CLOCK_50);
    RESET = 1'b1;
    #1;
    check("mr_scan", {24'd0, SCAN_CODE}, 32'h0);
    check("mr_flags", {28'd0, EXTENDED, BREAK, CODE_VALID, FRAME_ERR}, 32'h0);
`ifdef PS2_ERR_COUNT_EN
    check("mr_errcnt", {24'd0, ERR_COUNT}, 32'h0);
`endif
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h24, 1'b0);
    check("mr_cnt",  cv_cnt - cv0, 1);
    check("mr_code", {24'd0, cv_code}, 32'h24);
    check("mr_ext_brk", {30'd0, cv_ext, cv_brk}, 32'h0);
    check("mr_noerr", fe_cnt - fe0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
